// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer: decodes the opcode and drives datapath selects, enables and memory strobes.
// Optional instruction counter enabled by defining MU0_CTRL_PERF_EN.
module mu0_control #(
   parameter int COUNT_W = 16
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic [3:0]         F,
   input  logic               N,
   input  logic               Z,
   input  logic               Mem_Ready,
   output logic               Addr_sel,
   output logic               X_sel,
   output logic               Y_sel,
   output logic [1:0]         ALU_Fn,
   output logic               PC_En,
   output logic               ACC_En,
   output logic               IR_En,
   output logic               Rd,
   output logic               Wr,
   output logic               Fetch,
   output logic               Halted
`ifdef MU0_CTRL_PERF_EN
   ,
   output logic [COUNT_W-1:0] Instr_Count
`endif
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'b00,
      ST_EXECUTE = 2'b01,
      ST_HALT    = 2'b10
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   localparam logic [1:0] FN_PASS_B = 2'b00;
   localparam logic [1:0] FN_ADD    = 2'b01;
   localparam logic [1:0] FN_SUB    = 2'b10;
   localparam logic [1:0] FN_INC_A  = 2'b11;

   state_t r_state;
   state_t w_next;

   // State register
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and output decode; reset gating keeps strobes low while nReset is held
   always_comb begin
      Addr_sel = 1'b0;
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      ALU_Fn   = FN_PASS_B;
      PC_En    = 1'b0;
      ACC_En   = 1'b0;
      IR_En    = 1'b0;
      Rd       = 1'b0;
      Wr       = 1'b0;
      Fetch    = 1'b0;
      Halted   = 1'b0;
      w_next   = r_state;
      if (!nReset) begin
         Fetch  = 1'b1;
         w_next = ST_FETCH;
      end else begin
         case (r_state)
            ST_FETCH: begin
               Fetch  = 1'b1;
               Rd     = 1'b1;
               X_sel  = 1'b1;
               ALU_Fn = FN_INC_A;
               if (Mem_Ready) begin
                  IR_En  = 1'b1;
                  PC_En  = 1'b1;
                  w_next = ST_EXECUTE;
               end else begin
                  w_next = ST_FETCH;
               end
            end
            ST_EXECUTE: begin
               case (F)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     Addr_sel = 1'b1;
                     Rd       = 1'b1;
                     if (F == OP_ADD) begin
                        ALU_Fn = FN_ADD;
                     end else if (F == OP_SUB) begin
                        ALU_Fn = FN_SUB;
                     end else begin
                        ALU_Fn = FN_PASS_B;
                     end
                     if (Mem_Ready) begin
                        ACC_En = 1'b1;
                        w_next = ST_FETCH;
                     end else begin
                        w_next = ST_EXECUTE;
                     end
                  end
                  OP_STA: begin
                     Addr_sel = 1'b1;
                     Wr       = 1'b1;
                     if (Mem_Ready) begin
                        w_next = ST_FETCH;
                     end else begin
                        w_next = ST_EXECUTE;
                     end
                  end
                  // Jumps complete in one cycle regardless of memory
                  OP_JMP, OP_JGE, OP_JNE: begin
                     Y_sel  = 1'b1;
                     w_next = ST_FETCH;
                     if (F == OP_JGE) begin
                        PC_En = ~N;
                     end else if (F == OP_JNE) begin
                        PC_En = ~Z;
                     end else begin
                        PC_En = 1'b1;
                     end
                  end
                  OP_STP: begin
                     w_next = ST_HALT;
                  end
                  default: begin
                     w_next = ST_FETCH;
                  end
               endcase
            end
            ST_HALT: begin
               Halted = 1'b1;
               w_next = ST_HALT;
            end
            default: begin
               w_next = ST_FETCH;
            end
         endcase
      end
   end

`ifdef MU0_CTRL_PERF_EN
   logic               w_instr_done;
   logic [COUNT_W-1:0] r_instr_count;

   assign w_instr_done = (r_state == ST_EXECUTE) && (w_next != ST_EXECUTE);
   assign Instr_Count  = r_instr_count;

   // Completed-instruction counter, wraps naturally at its width
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_instr_count <= {COUNT_W{1'b0}};
      end else if (w_instr_done) begin
         r_instr_count <= r_instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_instr_count <= r_instr_count;
      end
   end
`endif

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Fetch/execute sequencer for the MU0 datapath.
- Decodes the 4-bit opcode held in IR and drives every datapath mux select (address, ALU X and Y operands), the register load enables, the ALU function, and the memory read/write strobes.
- Supports variable-latency memory through a single ready input.
- Sits between the instruction register and the datapath muxes/registers in the MU0 top level.

Parameters:
- COUNT_W, 16, width of the instruction counter (used only when MU0_CTRL_PERF_EN is defined).

Ports:
- Clk  input  1  system clock, rising-edge active.
- nReset  input  1  asynchronous, active-low reset.
- F  input  4  opcode, IR[15:12].
- N  input  1  ACC negative flag (ACC[15]).
- Z  input  1  ACC zero flag.
- Mem_Ready  input  1  memory has completed the current Rd/Wr this cycle.
- Addr_sel  output  1  0 = PC drives address, 1 = IR[11:0].
- X_sel  output  1  ALU A operand: 0 = ACC, 1 = PC.
- Y_sel  output  1  ALU B operand: 0 = memory read data, 1 = IR.
- ALU_Fn  output  2  00 = pass B, 01 = A+B, 10 = A-B, 11 = A+1.
- PC_En  output  1  PC load enable.
- ACC_En  output  1  ACC load enable.
- IR_En  output  1  IR load enable.
- Rd  output  1  memory read strobe.
- Wr  output  1  memory write strobe.
- Fetch  output  1  high while in FETCH.
- Halted  output  1  high while in HALT.
- Instr_Count  output  COUNT_W  completed-instruction count; present only when MU0_CTRL_PERF_EN is defined.

Behaviour:
- States: FETCH, EXECUTE, HALT (2-bit register). Reset state is FETCH.
- Outputs are decoded combinationally from state, F, N, Z and Mem_Ready.
- While nReset is low, PC_En, ACC_En, IR_En, Rd and Wr are forced to 0. Selects are 0 and ALU_Fn = 00. Fetch = 1, Halted = 0.
- FETCH:
  - Addr_sel=0, Rd=1, X_sel=1, ALU_Fn=11.
  - IR_En and PC_En are asserted only in the cycle where Mem_Ready=1. That cycle transitions to EXECUTE.
  - If Mem_Ready=0, stay in FETCH with Rd held.
- EXECUTE, by F:
  - 0 LDA: Addr_sel=1, Rd=1, Y_sel=0, ALU_Fn=00; ACC_En when Mem_Ready.
  - 1 STA: Addr_sel=1, Wr=1, X_sel=0 (ACC presented as write data).
  - 2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, ALU_Fn=01; ACC_En when Mem_Ready.
  - 3 SUB: as ADD but ALU_Fn=10.
  - 4 JMP: Y_sel=1, ALU_Fn=00, PC_En=1. Single cycle; Mem_Ready is ignored.
  - 5 JGE: as JMP when N=0; no enables when N=1. Single cycle.
  - 6 JNE: as JMP when Z=0; no enables when Z=1. Single cycle.
  - 7 STP: no strobes or enables; next state is HALT.
  - 8-F: NOP; no strobes; single cycle; returns to FETCH.
- Memory ops (LDA/STA/ADD/SUB): stay in EXECUTE with strobe held until Mem_Ready=1, then return to FETCH.
- HALT: all strobes and enables are 0, Halted=1. Only nReset exits HALT.
- Latency with zero wait states: 2 cycles per instruction (1 for STP to reach HALT).
- Mem_Ready high outside a strobe cycle is ignored.
- Asserting nReset mid-instruction aborts the instruction immediately: the strobe drops asynchronously, and the block restarts in FETCH on the first edge after release.
- At most one of Rd/Wr is high in any cycle.

Optional Feature:
- Macro: MU0_CTRL_PERF_EN.
- Defined:
  - Instr_Count resets to 0.
  - Increments by 1 on the clock edge that leaves EXECUTE, including STP.
  - Wraps from 2^COUNT_W-1 to 0.
  - Holds in HALT.
- Undefined: the Instr_Count port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then release with Mem_Ready=1 and F=0 (LDA) -> cycle 1: Fetch=1, Rd=1, IR_En=1, PC_En=1, ALU_Fn=11. Cycle 2: Addr_sel=1, Rd=1, ACC_En=1, ALU_Fn=00. Cycle 3: back in FETCH.
- FETCH with Mem_Ready held low for 3 cycles, then high -> Rd=1 for 4 cycles. IR_En/PC_En=0 for 3 cycles, then 1 in the 4th only.
- EXECUTE F=5: with N=1 -> PC_En=0; with N=0 -> PC_En=1, Y_sel=1. Repeat for F=6 with Z=1/0 -> PC_En=0/1.
- F=7 -> Halted=1 next cycle and stays 1 for 10 cycles with Rd=Wr=0. nReset pulse low -> Fetch=1, Halted=0.
- F=1 (STA) with Mem_Ready low, then nReset asserted mid-wait -> Wr drops to 0 without waiting for a clock edge. After release, Fetch=1.
- With MU0_CTRL_PERF_EN and COUNT_W=4: run 17 NOPs (F=8) -> Instr_Count reads 1 (wrapped), then 0 after reset.
